// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle core: sequences fetch/decode/execute/memory/writeback
// and drives the ALU control, operand-mux selects and all architectural write enables.
`ifndef WORD
`define WORD 32
`endif
`ifndef ALU_CONTROL_SIZE
`define ALU_CONTROL_SIZE 3
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_SLT
`define ALU_SLT 3'b101
`endif

module multicycle_ctrl (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [6:0]                     op,
  input  logic [2:0]                     funct3,
  input  logic                           funct7b5,
  input  logic                           mem_ready,
  output logic                           mem_req,
  output logic                           mem_write,
  output logic                           adr_src,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           reg_write,
  output logic [1:0]                     alu_src_a,
  output logic [1:0]                     alu_src_b,
  output logic [1:0]                     result_src,
  output logic [`ALU_CONTROL_SIZE-1:0]   ALUControl,
  output logic                           instr_done,
  output logic                           halt
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_ILLEGAL
  } state_t;

  state_t state, state_next;

  logic r_add, r_slt, i_add, i_slt;
  assign r_add = (funct3 == 3'b000) && !funct7b5;
  assign r_slt = (funct3 == 3'b010) && !funct7b5;
  assign i_add = (funct3 == 3'b000);
  assign i_slt = (funct3 == 3'b010);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_next = S_MEMADR;
        else if (op == OP_R)            state_next = S_EXECR;
        else if (op == OP_I)            state_next = S_EXECI;
        else if (op == OP_JAL)          state_next = S_JAL;
        else                            state_next = S_ILLEGAL;
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_MEMWB:    state_next = S_FETCH;
      S_EXECR:    state_next = (r_add || r_slt) ? S_ALUWB : S_ILLEGAL;
      S_EXECI:    state_next = (i_add || i_slt) ? S_ALUWB : S_ILLEGAL;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is high so a mid-instruction reset writes nothing.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    ALUControl = `ALU_ADD;
    instr_done = 1'b0;
    halt       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          if (r_slt) ALUControl = `ALU_SLT;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          if (i_slt) ALUControl = `ALU_SLT;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_ILLEGAL: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output words are queued
// as stimulus is driven and compared against the DUT at the falling edge.
`ifndef ALU_CONTROL_SIZE
`define ALU_CONTROL_SIZE 3
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_SLT
`define ALU_SLT 3'b101
`endif

module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [`ALU_CONTROL_SIZE-1:0] ALUControl;
  logic instr_done, halt;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .ALUControl(ALUControl),
    .instr_done(instr_done), .halt(halt)
  );

  always #5 clk = ~clk;

  localparam int OW = 14 + `ALU_CONTROL_SIZE;
  typedef logic [OW-1:0] ow_t;
  ow_t act;
  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, ALUControl, instr_done, halt};

  typedef enum int {E_RST, E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWRITE,
                    E_MEMWB, E_EXECR, E_EXECI, E_JAL, E_ALUWB, E_ILLEGAL} est_t;
  typedef enum int {K_LW, K_SW, K_R, K_I, K_JAL} kind_t;

  typedef struct {
    string name;
    logic [6:0] op;
    logic [2:0] f3;
    logic b5;
    int fs;
    int ms;
    kind_t kind;
    logic [`ALU_CONTROL_SIZE-1:0] alu;
    int cycles;
  } vec_t;

  ow_t exp_q[$];
  int nvec = 0;
  int nfail = 0;

  function automatic ow_t expect_of(est_t s, logic rdy, logic [`ALU_CONTROL_SIZE-1:0] alu);
    logic mr = 0, mw = 0, as = 0, ir = 0, pw = 0, rw = 0, dn = 0, h = 0;
    logic [1:0] a = 0, b = 0, rs = 0;
    logic [`ALU_CONTROL_SIZE-1:0] al = `ALU_ADD;
    case (s)
      E_RST:      al = '0;
      E_FETCH:    begin mr = 1; b = 2'b10; rs = 2'b10; ir = rdy; pw = rdy; end
      E_DECODE:   begin a = 2'b01; b = 2'b01; end
      E_MEMADR:   begin a = 2'b10; b = 2'b01; end
      E_MEMREAD:  begin mr = 1; as = 1; end
      E_MEMWRITE: begin mr = 1; mw = 1; as = 1; dn = rdy; end
      E_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
      E_EXECR:    begin a = 2'b10; al = alu; end
      E_EXECI:    begin a = 2'b10; b = 2'b01; al = alu; end
      E_JAL:      begin a = 2'b01; b = 2'b10; pw = 1; end
      E_ALUWB:    begin rw = 1; dn = 1; end
      E_ILLEGAL:  h = 1;
      default: ;
    endcase
    return {mr, mw, as, ir, pw, rw, a, b, rs, al, dn, h};
  endfunction

  task automatic step(input string name, input logic r, input logic rdy,
                      input ow_t e, output logic done);
    ow_t got_exp;
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    got_exp = exp_q.pop_front();
    nvec++;
    if (act !== got_exp) begin
      nfail++;
      $display("FAIL %s: outputs %b, required %b", name, act, got_exp);
    end
    done = instr_done;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input vec_t v);
    int cnt = 0;
    int done_at = -1;
    logic d;
    op = v.op; funct3 = v.f3; funct7b5 = v.b5;
    for (int i = 0; i < v.fs; i++) begin
      step({v.name, "/fetch_wait"}, 0, 0, expect_of(E_FETCH, 0, 0), d); cnt++;
    end
    step({v.name, "/fetch"}, 0, 1, expect_of(E_FETCH, 1, 0), d); cnt++;
    step({v.name, "/decode"}, 0, rnd(), expect_of(E_DECODE, 0, 0), d); cnt++;
    case (v.kind)
      K_LW, K_SW: begin
        est_t ms = (v.kind == K_LW) ? E_MEMREAD : E_MEMWRITE;
        step({v.name, "/memadr"}, 0, rnd(), expect_of(E_MEMADR, 0, 0), d); cnt++;
        for (int i = 0; i < v.ms; i++) begin
          step({v.name, "/mem_wait"}, 0, 0, expect_of(ms, 0, 0), d); cnt++;
          if (d) done_at = cnt;
        end
        step({v.name, "/mem"}, 0, 1, expect_of(ms, 1, 0), d); cnt++;
        if (d) done_at = cnt;
        if (v.kind == K_LW) begin
          step({v.name, "/memwb"}, 0, rnd(), expect_of(E_MEMWB, 0, 0), d); cnt++;
          if (d) done_at = cnt;
        end
      end
      default: begin
        est_t ex = (v.kind == K_R) ? E_EXECR : (v.kind == K_I) ? E_EXECI : E_JAL;
        step({v.name, "/exec"}, 0, rnd(), expect_of(ex, 0, v.alu), d); cnt++;
        step({v.name, "/aluwb"}, 0, rnd(), expect_of(E_ALUWB, 0, 0), d); cnt++;
        if (d) done_at = cnt;
      end
    endcase
    nvec++;
    if (done_at != v.cycles) begin
      nfail++;
      $display("FAIL %s/cpi: retired in cycle %0d, required %0d", v.name, done_at, v.cycles);
    end
  endtask

  task automatic illegal_hold(input string name);
    logic d;
    for (int i = 0; i < 20; i++)
      step({name, "/halt"}, 0, rnd(), expect_of(E_ILLEGAL, 0, 0), d);
    step({name, "/rst"}, 1, rnd(), expect_of(E_RST, 0, 0), d);
    step({name, "/after_rst"}, 0, 0, expect_of(E_FETCH, 0, 0), d);
  endtask

  vec_t tbl[9];
  logic d;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{"add",       7'b0110011, 3'b000, 1'b0, 0, 0, K_R,   `ALU_ADD, 4};
    tbl[1] = '{"lw_stall",  7'b0000011, 3'b010, 1'b0, 3, 2, K_LW,  `ALU_ADD, 10};
    tbl[2] = '{"slti",      7'b0010011, 3'b010, 1'b0, 0, 0, K_I,   `ALU_SLT, 4};
    tbl[3] = '{"sw",        7'b0100011, 3'b010, 1'b0, 0, 0, K_SW,  `ALU_ADD, 4};
    tbl[4] = '{"jal",       7'b1101111, 3'b000, 1'b0, 0, 0, K_JAL, `ALU_ADD, 4};
    tbl[5] = '{"slt_wait",  7'b0110011, 3'b010, 1'b0, 1, 0, K_R,   `ALU_SLT, 5};
    tbl[6] = '{"addi",      7'b0010011, 3'b000, 1'b1, 0, 0, K_I,   `ALU_ADD, 4};
    tbl[7] = '{"sw_stall",  7'b0100011, 3'b010, 1'b0, 0, 2, K_SW,  `ALU_ADD, 6};
    tbl[8] = '{"lw",        7'b0000011, 3'b010, 1'b0, 0, 0, K_LW,  `ALU_ADD, 5};

    step("reset0", 1, 1, expect_of(E_RST, 0, 0), d);
    step("reset1", 1, 1, expect_of(E_RST, 0, 0), d);

    foreach (tbl[i]) run_instr(tbl[i]);

    // Reset landing on the lw writeback cycle must suppress reg_write and instr_done.
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    step("midrst/fetch", 0, 1, expect_of(E_FETCH, 1, 0), d);
    step("midrst/decode", 0, 0, expect_of(E_DECODE, 0, 0), d);
    step("midrst/memadr", 0, 0, expect_of(E_MEMADR, 0, 0), d);
    step("midrst/memread", 0, 1, expect_of(E_MEMREAD, 1, 0), d);
    step("midrst/rst", 1, 1, expect_of(E_RST, 0, 0), d);
    step("midrst/fetch_again", 0, 0, expect_of(E_FETCH, 0, 0), d);
    step("midrst/fetch_go", 0, 1, expect_of(E_FETCH, 1, 0), d);
    step("midrst/decode2", 0, 0, expect_of(E_DECODE, 0, 0), d);
    step("midrst/memadr2", 0, 0, expect_of(E_MEMADR, 0, 0), d);
    step("midrst/memread2", 0, 1, expect_of(E_MEMREAD, 1, 0), d);
    step("midrst/memwb", 0, 0, expect_of(E_MEMWB, 0, 0), d);

    op = 7'b1110011; funct3 = 3'b000; funct7b5 = 1'b0;
    step("ill_op/fetch", 0, 1, expect_of(E_FETCH, 1, 0), d);
    step("ill_op/decode", 0, 0, expect_of(E_DECODE, 0, 0), d);
    illegal_hold("ill_op");

    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step("ill_r/fetch", 0, 1, expect_of(E_FETCH, 1, 0), d);
    step("ill_r/decode", 0, 0, expect_of(E_DECODE, 0, 0), d);
    step("ill_r/execr", 0, 0, expect_of(E_EXECR, 0, `ALU_ADD), d);
    illegal_hold("ill_r");

    op = 7'b0010011; funct3 = 3'b001; funct7b5 = 1'b0;
    step("ill_i/fetch", 0, 1, expect_of(E_FETCH, 1, 0), d);
    step("ill_i/decode", 0, 0, expect_of(E_DECODE, 0, 0), d);
    step("ill_i/execi", 0, 0, expect_of(E_EXECI, 0, `ALU_ADD), d);
    illegal_hold("ill_i");

    run_instr(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the multicycle core, directly upstream of the ALU: it sequences fetch, decode, execute, memory and writeback, and drives `ALUControl`, the operand-mux selects and every architectural write enable. Memory accesses use a req/ready handshake, so any state touching memory can stall. Supported instructions are lw, sw, add, slt, addi, slti and jal. Any other encoding parks the core in a sticky halt.

## Interface
Parameters:
- none; widths come from `` `WORD `` and `` `ALU_CONTROL_SIZE ``, and ALU codes from `` `ALU_ADD `` and `` `ALU_SLT ``.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  `instr[6:0]` from the instruction register.
- `funct3`  in  3  `instr[14:12]`.
- `funct7b5`  in  1  `instr[30]`.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_write`  out  1  the request is a store.
- `adr_src`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register and OldPC.
- `pc_write`  out  1  load the PC from the result bus.
- `reg_write`  out  1  register-file write of the result bus.
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- `alu_src_b`  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `result_src`  out  2  00 = ALUOut, 01 = mem data register, 10 = ALUResult.
- `ALUControl`  out  `` `ALU_CONTROL_SIZE ``  `` `ALU_ADD `` or `` `ALU_SLT ``.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `halt`  out  1  illegal instruction seen; sticky.

## Operation
States and transitions:
- **FETCH**
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, go to DECODE.
  - Otherwise stay, with all strobes 0.
- **DECODE**
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, ADD. ALUOut captures OldPC+imm for jal.
  - Next state by `op`: lw/sw (0000011/0100011) → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; else → ILLEGAL.
- **MEMADR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, ADD.
  - lw → MEMREAD; sw → MEMWRITE.
- **MEMREAD**
  - Outputs: `mem_req`=1, `adr_src`=1.
  - On `mem_ready` → MEMWB; otherwise stay.
- **MEMWRITE**
  - Outputs: `mem_req`=1, `mem_write`=1, `adr_src`=1.
  - On `mem_ready`: `instr_done`=1, go to FETCH; otherwise stay.
- **MEMWB**
  - Outputs: `result_src`=01, `reg_write`=1, `instr_done`=1.
  - → FETCH.
- **EXECR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00.
  - funct3 000 with `funct7b5`=0 → ADD; funct3 010 with `funct7b5`=0 → SLT; other combinations → ILLEGAL.
  - → ALUWB when legal.
- **EXECI**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01.
  - funct3 000 → ADD; funct3 010 → SLT; else → ILLEGAL.
  - → ALUWB when legal.
- **JAL**
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1.
  - The PC takes the target from ALUOut; ALUOut then captures OldPC+4.
  - → ALUWB.
- **ALUWB**
  - Outputs: `result_src`=00, `reg_write`=1, `instr_done`=1.
  - → FETCH.
- **ILLEGAL**
  - Outputs: `halt`=1, all strobes 0.
  - Leaves only on `rst`.

General rules:
- Any output not listed for a state is 0 in that state. `ALUControl` defaults to `` `ALU_ADD ``; it is never left undriven.
- `mem_ready` is ignored whenever `mem_req`=0.
- `mem_write`=1 only together with `mem_req`=1.
- `ir_write` and `pc_write` must never pulse twice for one fetch.

## Timing
- Reset:
  - A cycle with `rst`=1 sets state to FETCH on that edge.
  - While `rst` is high, every output is 0, including `mem_req` and `halt`.
  - Reset mid-instruction abandons it: no register or PC write occurs in that cycle.
- Outputs are decoded from state plus `mem_ready`, `op` and `funct3`; no extra register stage.
- With `mem_ready` tied to 1, FETCH lasts 1 cycle. Cycles per instruction:
  - lw: 5
  - sw: 4
  - add, slt, addi, slti: 4
  - jal: 4
- Each cycle with `mem_ready`=0 in a memory state adds exactly 1 cycle and changes no other output.
- `mem_ready` may assert in the very first cycle of `mem_req`.
- `instr_done` pulses exactly once per retired instruction, in the final cycle. It never pulses for an illegal instruction.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → all outputs 0; first cycle after release is FETCH with `mem_req`=1 and `adr_src`=0.
- **add, zero-wait memory:** op=0110011, funct3=000, b5=0, `mem_ready`=1 → `instr_done` in cycle 4.
  - EXECR drives `` `ALU_ADD ``, src_a=10, src_b=00.
  - `reg_write`=1 only in ALUWB.
- **lw with memory stalls:** `mem_ready`=0 for 3 cycles in FETCH and 2 cycles in MEMREAD → retire in cycle 10.
  - `ir_write` pulses exactly once.
  - `reg_write`=1 only in MEMWB, with `result_src`=01.
- **slti, then sw:**
  - slti → EXECI drives `` `ALU_SLT ``, src_b=01.
  - sw → `mem_write`=1 only together with `mem_req`; `reg_write` never 1; retires in 4 cycles.
- **jal:** `pc_write` pulses in FETCH and JAL (`result_src`=00); `reg_write` in ALUWB; total 4 cycles.
- **Illegal encodings:**
  - op=1110011 → ILLEGAL; `halt`=1 from the next cycle and held for 20 cycles, with no strobes.
  - R-type with b5=1 does the same.
  - `rst` → FETCH and `halt`=0.
